// File: rtl/rv32_multicycle.sv
// Multicycle RV32I/RV32E integer core (no CSRs) with a single shared memory port
// using a ready handshake; illegal or misaligned operations halt in a sticky trap.
module rv32_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        enable_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] addr_o,
  output logic [31:0] wvalue_o,
  input  logic [31:0] rvalue_i,
  input  logic        ready_i,
  output logic        retire_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o,
  output logic [31:0] trap_pc_o
);
  localparam int AW = (NREGS == 16) ? 4 : 5;

  if (NREGS != 16 && NREGS != 32) begin : g_bad_nregs
    $error("rv32_multicycle: NREGS must be 16 (RV32E) or 32 (RV32I)");
  end

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_OPI = 7'b0010011, OP_OP = 7'b0110011,
                         OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

  typedef enum logic [2:0] {S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] pc_q, ir_q, rs1v_q, rs2v_q, res_q, addr_q, npc_q, tpc_q;
  logic [31:0] regs_q [NREGS];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_sys;
  assign is_lui   = (opc == OP_LUI);
  assign is_auipc = (opc == OP_AUIPC);
  assign is_jal   = (opc == OP_JAL);
  assign is_jalr  = (opc == OP_JALR);
  assign is_br    = (opc == OP_BR);
  assign is_ld    = (opc == OP_LD);
  assign is_st    = (opc == OP_ST);
  assign is_opi   = (opc == OP_OPI);
  assign is_op    = (opc == OP_OP);
  assign is_sys   = (opc == OP_SYS);

  logic writes_rd, uses_rs1, uses_rs2, known, bad_idx;
  assign writes_rd = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op;
  assign uses_rs1  = is_jalr | is_br | is_ld | is_st | is_opi | is_op;
  assign uses_rs2  = is_br | is_st | is_op;
  // Only RV32E can see an out-of-range index: bit 4 selects x16..x31.
  assign bad_idx = (NREGS == 16) &&
                   ((writes_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]));

  always_comb begin
    known = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL: known = 1'b1;
      OP_JALR:  known = (f3 == 3'd0);
      OP_BR:    known = (f3 != 3'd2) && (f3 != 3'd3);
      OP_LD:    known = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      OP_ST:    known = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      OP_OPI:   known = (f3 == 3'd1) ? (f7 == 7'h00) :
                        (f3 == 3'd5) ? ((f7 == 7'h00) || (f7 == 7'h20)) : 1'b1;
      OP_OP:    known = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      OP_FENCE: known = (f3 == 3'd0) || (f3 == 3'd1);
      OP_SYS:   known = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);
      default:  known = 1'b0;
    endcase
  end

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  function automatic logic [31:0] alu(input logic [2:0] f, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    if (alt) alu = $unsigned($signed(a) >>> b[4:0]);
               else     alu = a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] idx);
    rd_reg = (idx == 5'd0) ? 32'd0 : regs_q[idx[AW-1:0]];
  endfunction

  // SUB/SRA select only exists for register ops and shift-right immediates.
  logic        alt, taken, jump, mis_tgt, mis_mem;
  logic [31:0] pc4, alu_res, ea, target, exec_res, lsh, ld_val, st_data;
  logic [3:0]  st_strb;
  assign alt     = ir_q[30] && (is_op || (f3 == 3'd5));
  assign pc4     = pc_q + 32'd4;
  assign alu_res = alu(f3, alt, rs1v_q, is_op ? rs2v_q : imm_i);
  assign ea      = rs1v_q + (is_st ? imm_s : imm_i);
  assign target  = is_jal ? pc_q + imm_j : is_jalr ? (ea & ~32'd1) : pc_q + imm_b;
  assign jump    = is_jal | is_jalr | (is_br & taken);
  assign mis_tgt = jump & target[1];
  assign mis_mem = (is_ld | is_st) &
                   (((f3[1:0] == 2'd1) & ea[0]) | ((f3[1:0] == 2'd2) & (ea[1:0] != 2'd0)));
  assign exec_res = is_lui ? imm_u : is_auipc ? pc_q + imm_u :
                    (is_jal | is_jalr) ? pc4 : alu_res;

  always_comb begin
    case (f3)
      3'd0:    taken = (rs1v_q == rs2v_q);
      3'd1:    taken = (rs1v_q != rs2v_q);
      3'd4:    taken = ($signed(rs1v_q) < $signed(rs2v_q));
      3'd5:    taken = ($signed(rs1v_q) >= $signed(rs2v_q));
      3'd6:    taken = (rs1v_q < rs2v_q);
      default: taken = (rs1v_q >= rs2v_q);
    endcase
  end

  assign lsh = rvalue_i >> {addr_q[1:0], 3'b000};
  always_comb begin
    case (f3)
      3'd0:    ld_val = {{24{lsh[7]}}, lsh[7:0]};
      3'd1:    ld_val = {{16{lsh[15]}}, lsh[15:0]};
      3'd4:    ld_val = {24'd0, lsh[7:0]};
      3'd5:    ld_val = {16'd0, lsh[15:0]};
      default: ld_val = lsh;
    endcase
    case (f3)
      3'd0:    begin st_strb = 4'b0001 << addr_q[1:0]; st_data = {4{rs2v_q[7:0]}};  end
      3'd1:    begin st_strb = 4'b0011 << addr_q[1:0]; st_data = {2{rs2v_q[15:0]}}; end
      default: begin st_strb = 4'b1111;                st_data = rs2v_q;            end
    endcase
  end

  always_comb begin
    enable_o = 1'b0;
    wstrb_o  = 4'b0;
    addr_o   = 32'd0;
    wvalue_o = 32'd0;
    if (state_q == S_FETCH) begin
      enable_o = 1'b1;
      addr_o   = pc_q;
    end else if (state_q == S_MEM) begin
      enable_o = 1'b1;
      addr_o   = addr_q;
      if (is_st) begin
        wstrb_o  = st_strb;
        wvalue_o = st_data;
      end
    end
  end

  assign retire_o     = (state_q == S_WB);
  assign trap_o       = (state_q == S_TRAP);
  assign trap_cause_o = cause_q;
  assign trap_pc_o    = tpc_q;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: if (ready_i) state_d = S_DECODE;
      S_DECODE:
        if (!known || bad_idx) begin state_d = S_TRAP; cause_d = 2'd0; end
        else if (is_sys)       begin state_d = S_TRAP; cause_d = 2'd3; end
        else                   state_d = S_EXECUTE;
      S_EXECUTE:
        if (mis_tgt)             begin state_d = S_TRAP; cause_d = 2'd1; end
        else if (mis_mem)        begin state_d = S_TRAP; cause_d = 2'd2; end
        else if (is_ld || is_st) state_d = S_MEM;
        else                     state_d = S_WB;
      S_MEM:   if (ready_i) state_d = S_WB;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_START;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q   <= RESET_PC;
      ir_q   <= 32'd0;
      rs1v_q <= 32'd0;
      rs2v_q <= 32'd0;
      res_q  <= 32'd0;
      addr_q <= 32'd0;
      npc_q  <= 32'd0;
      tpc_q  <= 32'd0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'd0;
    end else begin
      case (state_q)
        S_FETCH:   if (ready_i) ir_q <= rvalue_i;
        S_DECODE:  begin rs1v_q <= rd_reg(rs1); rs2v_q <= rd_reg(rs2); end
        S_EXECUTE: begin res_q <= exec_res; addr_q <= ea; npc_q <= jump ? target : pc4; end
        S_MEM:     if (ready_i && is_ld) res_q <= ld_val;
        S_WB: begin
          pc_q <= npc_q;
          if (writes_rd && rd != 5'd0) regs_q[rd[AW-1:0]] <= res_q;
        end
        default: ;
      endcase
      if (state_d == S_TRAP && state_q != S_TRAP) tpc_q <= pc_q;
    end
  end
endmodule

// File: tb/tb_rv32_multicycle.sv
// Directed bench: an RV32I core on a wait-state memory model and an RV32E core
// with a single-instruction memory for decode traps and reset behaviour.
module tb_rv32_multicycle;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // RV32I instance on a program/data memory with programmable wait states
  logic        rstn, en, ready, retire, trap;
  logic [3:0]  wstrb;
  logic [31:0] addr, wval, rval, tpc;
  logic [1:0]  cause;

  rv32_multicycle #(.RESET_PC(32'h0), .NREGS(32)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .enable_o(en), .wstrb_o(wstrb), .addr_o(addr),
    .wvalue_o(wval), .rvalue_i(rval), .ready_i(ready), .retire_o(retire),
    .trap_o(trap), .trap_cause_o(cause), .trap_pc_o(tpc));

  // RV32E instance; every fetch returns instr_e
  logic        rstn_e, en_e, ready_e, retire_e, trap_e, hold_e;
  logic [3:0]  wstrb_e;
  logic [31:0] addr_e, wval_e, instr_e, tpc_e;
  logic [1:0]  cause_e;

  rv32_multicycle #(.RESET_PC(32'h40), .NREGS(16)) u_dut_e (
    .clk_i(clk), .rstn_i(rstn_e), .enable_o(en_e), .wstrb_o(wstrb_e), .addr_o(addr_e),
    .wvalue_o(wval_e), .rvalue_i(instr_e), .ready_i(ready_e), .retire_o(retire_e),
    .trap_o(trap_e), .trap_cause_o(cause_e), .trap_pc_o(tpc_e));
  assign ready_e = en_e && !hold_e;

  logic [31:0] prog [0:63];
  logic [31:0] dmem [0:255];
  int          waits, wcnt, nret, stab_err, cyc;
  int          ret_cyc [0:63];
  logic        acc_open;
  logic [67:0] acc_sig;
  logic [3:0]  sb_strb;
  logic [31:0] sb_wval;

  assign rval  = (addr[31:8] == 24'd0) ? prog[addr[7:2]] : dmem[addr[9:2]];
  assign ready = en && (wcnt >= waits);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
      wcnt <= 0; nret <= 0; stab_err <= 0; acc_open <= 1'b0;
      sb_strb <= 4'd0; sb_wval <= 32'd0;
    end else begin
      if (en && ready) begin
        wcnt <= 0;
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) dmem[addr[9:2]][8*b +: 8] <= wval[8*b +: 8];
        if (wstrb != 4'd0 && addr == 32'h103) begin sb_strb <= wstrb; sb_wval <= wval; end
      end else if (en) wcnt <= wcnt + 1;
      if (en) begin
        if (acc_open && ({addr, wstrb, wval} != acc_sig)) stab_err <= stab_err + 1;
        acc_open <= !ready;
        acc_sig  <= {addr, wstrb, wval};
      end else acc_open <= 1'b0;
      if (retire) begin
        if (nret < 64) ret_cyc[nret] <= cyc;
        nret <= nret + 1;
      end
    end
  end

  function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] e_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] e_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_prog(input int w, input string p);
    waits = w;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (trap) break;
    end
    chk({p, "_trap"}, {31'd0, trap}, 32'd1);
    chk({p, "_cause"}, {30'd0, cause}, 32'd1);
    chk({p, "_trap_pc"}, tpc, 32'h58);
    chk({p, "_jal_no_rd"}, u_dut.regs_q[12], 32'd0);
    chk({p, "_srli"}, dmem[8'h80], 32'h0000_000F);
    chk({p, "_srai"}, dmem[8'h81], 32'hFFFF_FFFF);
    chk({p, "_sltu"}, dmem[8'h82], 32'd1);
    chk({p, "_sub"}, dmem[8'h83], 32'd1);
    chk({p, "_sb_strb"}, {28'd0, sb_strb}, 32'h8);
    chk({p, "_sb_wval"}, sb_wval, 32'hA5A5_A5A5);
    chk({p, "_sb_word"}, dmem[8'h40], 32'hA500_0000);
    chk({p, "_lb"}, dmem[8'h84], 32'hFFFF_FFA5);
    chk({p, "_lbu"}, dmem[8'h85], 32'h0000_00A5);
    chk({p, "_blt_taken"}, dmem[8'h86], 32'd0);
    chk({p, "_bltu_not_taken"}, dmem[8'h87], 32'h66);
    chk({p, "_retired"}, nret, 32'd21);
    chk({p, "_alu_gap1"}, ret_cyc[1] - ret_cyc[0], 32'(4 + w));
    chk({p, "_alu_gap4"}, ret_cyc[4] - ret_cyc[3], 32'(4 + w));
    chk({p, "_store_gap"}, ret_cyc[5] - ret_cyc[4], 32'(5 + 2 * w));
    chk({p, "_stable"}, stab_err, 32'd0);
    repeat (5) @(negedge clk);
    chk({p, "_halt_en"}, {31'd0, en}, 32'd0);
  endtask

  task automatic run_e(input logic [31:0] ins, input logic [1:0] exp_cause, input string p);
    instr_e = ins;
    rstn_e = 1'b0;
    @(negedge clk);
    rstn_e = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (trap_e) break;
    end
    chk({p, "_trap"}, {31'd0, trap_e}, 32'd1);
    chk({p, "_cause"}, {30'd0, cause_e}, {30'd0, exp_cause});
    chk({p, "_trap_pc"}, tpc_e, 32'h40);
  endtask

  initial begin
    int n;
    rstn = 1'b0; rstn_e = 1'b0; hold_e = 1'b0; waits = 0; instr_e = 32'd0; cyc = 0;
    for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0013;
    prog[0]  = e_i(-1, 0, 0, 1, 7'h13);
    prog[1]  = e_i(28, 1, 5, 2, 7'h13);
    prog[2]  = e_i(32'h404, 1, 5, 3, 7'h13);
    prog[3]  = e_r(0, 1, 0, 3, 4);
    prog[4]  = e_r(32, 1, 0, 0, 5);
    prog[5]  = e_s(32'h200, 2, 0, 2);
    prog[6]  = e_s(32'h204, 3, 0, 2);
    prog[7]  = e_s(32'h208, 4, 0, 2);
    prog[8]  = e_s(32'h20C, 5, 0, 2);
    prog[9]  = e_i(32'hA5, 0, 0, 6, 7'h13);
    prog[10] = e_s(32'h103, 6, 0, 0);
    prog[11] = e_i(32'h103, 0, 0, 7, 7'h03);
    prog[12] = e_i(32'h103, 0, 4, 8, 7'h03);
    prog[13] = e_s(32'h210, 7, 0, 2);
    prog[14] = e_s(32'h214, 8, 0, 2);
    prog[15] = e_i(1, 0, 0, 9, 7'h13);
    prog[16] = e_b(8, 9, 1, 4);
    prog[17] = e_i(32'h55, 0, 0, 10, 7'h13);
    prog[18] = e_b(8, 9, 1, 6);
    prog[19] = e_i(32'h66, 0, 0, 11, 7'h13);
    prog[20] = e_s(32'h218, 10, 0, 2);
    prog[21] = e_s(32'h21C, 11, 0, 2);
    prog[22] = e_j(6, 12);

    repeat (3) @(negedge clk);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wvalue", wval, 32'd0);
    chk("rst_ctrl", {23'd0, en, wstrb, retire, trap, cause}, 32'd0);
    chk("rst_trap_pc", tpc, 32'd0);

    run_prog(0, "zw");
    run_prog(3, "ws");

    run_e(e_i(1, 0, 0, 17, 7'h13), 2'd0, "e_bad_rd");
    run_e(e_i(32'h102, 0, 2, 1, 7'h03), 2'd2, "e_lw_mis");
    run_e(32'h0010_0073, 2'd3, "e_ebreak");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en_e) n++;
    end
    chk("e_ebreak_no_enable", n, 32'd0);

    // Advance pc past RESET_PC, then stall a fetch and reset in the middle of it.
    instr_e = e_i(1, 0, 0, 1, 7'h13);
    rstn_e = 1'b0;
    @(negedge clk);
    rstn_e = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (retire_e) n++;
      if (n == 2) break;
    end
    hold_e = 1'b1;
    @(negedge clk);
    chk("e_stalled_fetch_pc", addr_e, 32'h48);
    chk("e_stalled_fetch_en", {31'd0, en_e}, 32'd1);
    rstn_e = 1'b0;
    #1;
    chk("e_rst_addr", addr_e, 32'd0);
    chk("e_rst_ctrl", {23'd0, en_e, wstrb_e, retire_e, trap_e, cause_e}, 32'd0);
    chk("e_rst_wval_tpc", wval_e | tpc_e, 32'd0);
    @(negedge clk);
    hold_e = 1'b0;
    rstn_e = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (en_e) break;
      @(negedge clk);
    end
    chk("e_first_req_en", {31'd0, en_e}, 32'd1);
    chk("e_first_req_addr", addr_e, 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv32_multicycle.md
# rv32_multicycle

Parametrised multicycle RV32I/RV32E integer core, successor to the base `cpu`. It executes the full RV32I base integer set except CSR instructions, one instruction at a time. Memory is accessed through a single shared instruction/data port with a ready handshake, so wait states are supported. Loads and stores are lane-aligned. Illegal or misaligned operations stop the core in a sticky trap state.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NREGS`, default 32: architectural registers.
  - 32 selects RV32I; 16 selects RV32E.
  - Any other value is a parameter error (elaboration-time assertion).
- `clk_i` in 1: clock. All state updates on the rising edge.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `enable_o` out 1: memory request valid.
- `wstrb_o` out 4: byte write strobes. 0 = read.
- `addr_o` out 32: byte address. Word-aligned on fetches.
- `wvalue_o` out 32: store data, placed on the byte lanes selected by `addr_o[1:0]`.
- `rvalue_i` in 32: read data. Valid in the cycle `ready_i`=1.
- `ready_i` in 1: request completes in this cycle.
- `retire_o` out 1: one-cycle pulse per retired instruction.
- `trap_o` out 1: sticky. Core halted.
- `trap_cause_o` out 2: valid while `trap_o`=1.
  - 0: illegal instruction.
  - 1: misaligned jump or branch target.
  - 2: misaligned load or store.
  - 3: ECALL or EBREAK.
- `trap_pc_o` out 32: PC of the faulting instruction.

## Operation
- States and transitions:
  - START → FETCH.
  - FETCH → DECODE on `ready_i`.
  - DECODE → EXECUTE, or TRAP.
  - EXECUTE → MEM (load/store), WRITEBACK, or TRAP.
  - MEM → WRITEBACK on `ready_i`.
  - WRITEBACK → FETCH.
  - TRAP is terminal. Only reset leaves it.
- FETCH: `enable_o`=1, `addr_o`=pc, `wstrb_o`=0. The instruction register latches `rvalue_i` when `ready_i`=1.
- DECODE:
  - Reads rs1/rs2. x0 always reads 0.
  - Traps with cause 0 on: unknown opcode; unknown funct3/funct7; any rd/rs1/rs2 index ≥ NREGS.
  - Traps with cause 3 on ECALL/EBREAK.
  - FENCE/FENCE.I decode as no-ops.
- EXECUTE: ALU computes one of:
  - ADD/SUB.
  - SLL/SRL/SRA. Shift amount is the low 5 bits of rs2 or imm.
  - SLT/SLTU.
  - XOR/OR/AND.
  - LUI/AUIPC results.
  - Link value pc+4.
  - Branch compare: BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Effective address: rs1+imm for loads/stores and JALR; JALR clears bit 0.
- EXECUTE trap checks:
  - Taken branch, JAL or JALR whose target has bit 1 set → cause 1.
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0 → cause 2.
- MEM, load:
  - `enable_o`=1, `addr_o`=effective address (byte-exact), `wstrb_o`=0.
  - Data is extracted from lane `addr[1:0]`, then sign- or zero-extended.
- MEM, store:
  - SB strobe 4'b0001<<addr[1:0]; SH strobe 4'b0011<<addr[1:0]; SW strobe 4'b1111.
  - `wvalue_o` = rs2 replicated across lanes (byte ×4, half ×2).
- WRITEBACK:
  - Writes rd if the instruction produces a result and rd≠0.
  - Sets pc to the target (taken branch or jump) or to pc+4.
  - Pulses `retire_o`.
- Trap:
  - No register write, no pc change, no retire pulse.
  - `enable_o`=0 from the TRAP state onward.
- Arithmetic: all arithmetic is 32-bit modulo 2^32; pc+4 wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset values (asynchronous, immediate on `rstn_i`=0):
  - State START, pc=`RESET_PC`, all registers 0.
  - `enable_o`=0, `wstrb_o`=0, `addr_o`=0, `wvalue_o`=0.
  - `retire_o`=0, `trap_o`=0, `trap_cause_o`=0, `trap_pc_o`=0.
- Memory outputs are combinational from state and registers. They stay stable for the whole time `enable_o`=1, up to and including the `ready_i` cycle. They are 0 in all other states.
- `ready_i` is ignored when `enable_o`=0.
- Latency with zero wait states (`ready_i` tied 1):
  - ALU, branch and jump instructions: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Loads and stores: 5 cycles.
  - Each wait cycle adds 1.
- `retire_o` is high in the WRITEBACK cycle.
- `trap_o` rises in the cycle after the detecting state.
- Reset asserted mid-access aborts the access immediately. The outstanding request is dropped and is not re-issued.

## Test plan
- ALU program, `ready_i`=1:
  - Stimulus: `addi x1,x0,-1; srli x2,x1,28; srai x3,x1,4; sltu x4,x0,x1; sub x5,x0,x1`.
  - Required: x2=0xF, x3=0xFFFFFFFF, x4=1, x5=1. `retire_o` pulses every 4 cycles.
- Byte-lane stores and loads:
  - Stimulus: `sb` 0xA5 to address 0x103, then `lb`/`lbu` from 0x103.
  - Required: `wstrb_o`=4'b1000, `wvalue_o`=0xA5A5A5A5. Loads return 0xFFFFFFA5 and 0x000000A5.
- Wait states: `ready_i` low for 3 cycles on every access.
  - Required: `addr_o`, `wstrb_o` and `wvalue_o` held stable throughout. A store completes in 5+6 cycles. Results match the zero-wait-state run.
- Branches:
  - Stimulus: BLT with rs1=-1, rs2=1, then BLTU on the same operands.
  - Required: BLT taken and BLTU not taken.
  - Stimulus: JAL to offset +6.
  - Required: trap cause 1, `trap_pc_o` = PC of the JAL, no rd write.
- NREGS=16:
  - Stimulus: `addi x17,x0,1`.
  - Required: trap cause 0.
  - Stimulus: `lw` from 0x102.
  - Required: trap cause 2.
- Reset behaviour:
  - Stimulus: EBREAK.
  - Required: trap cause 3, `enable_o` stays 0.
  - Stimulus: assert `rstn_i` low mid-FETCH, then release.
  - Required: all outputs 0 during reset. The first request after release is at `RESET_PC`.
